// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM states,
// line-control encodings and the FIFO occupancy width.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Word length relative to DATA_WIDTH: 0..3 = DATA_WIDTH-3..DATA_WIDTH bits
    typedef enum logic [1:0] {
        WLS_MINUS3 = 2'd0,
        WLS_MINUS2 = 2'd1,
        WLS_MINUS1 = 2'd2,
        WLS_FULL   = 2'd3
    } wls_e;

    // Parity mode, encoded as {sp, eps}
    typedef enum logic [1:0] {
        PAR_ODD   = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic parity_bit(input par_mode_e mode, input logic data_xor);
        case (mode)
            PAR_ODD:  return ~data_xor;
            PAR_EVEN: return data_xor;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous clear; push is accepted when full
// only if a pop happens in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // clear wins over a same-cycle push
    assign do_push = push && !clear && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: TX FIFO plus oversampled serialiser with parity,
// configurable stop length, break and CTS flow control.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                               apb_clk_in,
    input  logic                               apb_rst_in,
    input  logic                               bclk_in,
    input  logic [DATA_WIDTH-1:0]              thr_wdata_in,
    input  logic                               thr_write_in,
    input  logic [1:0]                         wls_in,
    input  logic                               stb_in,
    input  logic                               pen_in,
    input  logic                               eps_in,
    input  logic                               sp_in,
    input  logic                               bc_in,
    input  logic                               fifoen_in,
    input  logic                               txclr_in,
    input  logic                               afe_in,
    input  logic                               cts_in,
    output logic                               uart_txd_out,
    output logic                               thre_out,
    output logic                               temt_out,
    output logic [level_width(FIFO_DEPTH)-1:0] fifo_level_out,
    output logic                               overflow_out
);

    localparam int LW = level_width(FIFO_DEPTH);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);

    tx_state_e             state_q, state_nxt;
    logic [TW-1:0]         tick_q, tick_nxt;
    logic [BW-1:0]         bit_q, bit_nxt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nxt;

    // Per-character settings captured when the character is popped
    logic [BW-1:0]         last_bit_q;
    logic                  pen_q;
    logic                  par_q;
    logic [TW-1:0]         stop_last_q;

    logic                  txd_q;
    logic                  overflow_q;
    logic                  line_nxt;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LW-1:0]         fifo_level;

    logic                  at_cap;
    logic                  flow_ok;
    logic                  tick_last;
    logic                  stop_last;
    logic                  launch;
    logic                  push_ok;
    logic                  overflow_nxt;

    logic [DATA_WIDTH-1:0] char_mask;
    logic                  char_par;
    logic [TW-1:0]         char_stop_last;
    logic [BW-1:0]         char_last_bit;

    assign at_cap    = fifoen_in ? fifo_full : (fifo_level != '0);
    assign flow_ok   = !afe_in || cts_in;
    assign tick_last = (tick_q == TW'(OVERSAMPLE - 1));
    assign stop_last = (tick_q == stop_last_q);

    // The idle decision is also taken at the final stop tick so that queued
    // characters follow with no gap between stop and start.
    assign launch = bclk_in && !fifo_empty && flow_ok &&
                    (state_q == ST_IDLE || (state_q == ST_STOP && stop_last));

    assign push_ok      = thr_write_in && !txclr_in && (!at_cap || launch);
    assign overflow_nxt = thr_write_in && !txclr_in && at_cap && !launch;

    assign char_mask      = {DATA_WIDTH{1'b1}} >> (2'd3 - wls_in);
    assign char_par       = parity_bit(par_mode_e'({sp_in, eps_in}), ^(fifo_rdata & char_mask));
    assign char_last_bit  = BW'(DATA_WIDTH - 4) + BW'(wls_in);
    assign char_stop_last = !stb_in                          ? TW'(OVERSAMPLE - 1) :
                            (wls_e'(wls_in) == WLS_MINUS3)   ? TW'(OVERSAMPLE * 3 / 2 - 1) :
                                                               TW'(2 * OVERSAMPLE - 1);

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (apb_clk_in),
        .rst   (apb_rst_in),
        .clear (txclr_in),
        .push  (push_ok),
        .pop   (launch),
        .wdata (thr_wdata_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge apb_clk_in) begin
        if (apb_rst_in) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            last_bit_q  <= '0;
            pen_q       <= 1'b0;
            par_q       <= 1'b0;
            stop_last_q <= TW'(OVERSAMPLE - 1);
            txd_q       <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            tick_q     <= tick_nxt;
            bit_q      <= bit_nxt;
            shift_q    <= shift_nxt;
            txd_q      <= bc_in ? 1'b0 : line_nxt;
            overflow_q <= overflow_nxt;
            if (launch) begin
                last_bit_q  <= char_last_bit;
                pen_q       <= pen_in;
                par_q       <= char_par;
                stop_last_q <= char_stop_last;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        tick_nxt  = tick_q;
        bit_nxt   = bit_q;
        shift_nxt = shift_q;
        if (launch) begin
            state_nxt = ST_START;
            tick_nxt  = '0;
            bit_nxt   = '0;
            shift_nxt = fifo_rdata;
        end else if (bclk_in) begin
            case (state_q)
                ST_START: begin
                    if (tick_last) begin
                        state_nxt = ST_DATA;
                        tick_nxt  = '0;
                    end else begin
                        tick_nxt = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_last) begin
                        tick_nxt  = '0;
                        shift_nxt = shift_q >> 1;
                        if (bit_q == last_bit_q) begin
                            state_nxt = pen_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_nxt = bit_q + BW'(1);
                        end
                    end else begin
                        tick_nxt = tick_q + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_last) begin
                        state_nxt = ST_STOP;
                        tick_nxt  = '0;
                    end else begin
                        tick_nxt = tick_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (stop_last) begin
                        state_nxt = ST_IDLE;
                        tick_nxt  = '0;
                    end else begin
                        tick_nxt = tick_q + TW'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Line level is computed from the next state so the registered output
    // changes on the same edge as the state.
    always_comb begin
        case (state_nxt)
            ST_START:  line_nxt = 1'b0;
            ST_DATA:   line_nxt = shift_nxt[0];
            ST_PARITY: line_nxt = par_q;
            default:   line_nxt = 1'b1;
        endcase
    end

    assign uart_txd_out   = txd_q;
    assign overflow_out   = overflow_q;
    assign fifo_level_out = fifo_level;
    assign thre_out       = fifo_empty;
    assign temt_out       = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frame shape and timing, parity, stop
// length, FIFO capacity/overflow, flush, flow control, break and reset.
module tb_uart_tx_core;

    localparam int OS = 16;

    logic       apb_clk_in;
    logic       apb_rst_in;
    logic       bclk_in;
    logic [7:0] thr_wdata_in;
    logic       thr_write_in;
    logic [1:0] wls_in;
    logic       stb_in;
    logic       pen_in;
    logic       eps_in;
    logic       sp_in;
    logic       bc_in;
    logic       fifoen_in;
    logic       txclr_in;
    logic       afe_in;
    logic       cts_in;
    logic       uart_txd_out;
    logic       thre_out;
    logic       temt_out;
    logic [4:0] fifo_level_out;
    logic       overflow_out;

    int checks = 0;
    int errors = 0;

    uart_tx_core #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .OVERSAMPLE (OS)
    ) dut (
        .apb_clk_in     (apb_clk_in),
        .apb_rst_in     (apb_rst_in),
        .bclk_in        (bclk_in),
        .thr_wdata_in   (thr_wdata_in),
        .thr_write_in   (thr_write_in),
        .wls_in         (wls_in),
        .stb_in         (stb_in),
        .pen_in         (pen_in),
        .eps_in         (eps_in),
        .sp_in          (sp_in),
        .bc_in          (bc_in),
        .fifoen_in      (fifoen_in),
        .txclr_in       (txclr_in),
        .afe_in         (afe_in),
        .cts_in         (cts_in),
        .uart_txd_out   (uart_txd_out),
        .thre_out       (thre_out),
        .temt_out       (temt_out),
        .fifo_level_out (fifo_level_out),
        .overflow_out   (overflow_out)
    );

    initial begin
        apb_clk_in = 1'b0;
        forever #5 apb_clk_in = ~apb_clk_in;
    end

    // One bclk tick every third clock cycle
    initial begin
        int div = 0;
        bclk_in = 1'b0;
        forever begin
            @(posedge apb_clk_in);
            #1;
            bclk_in = (div == 2);
            div = (div == 2) ? 0 : div + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        thr_wdata_in = d;
        thr_write_in = 1'b1;
        @(negedge apb_clk_in);
        thr_write_in = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int cyc = 0;
        while (uart_txd_out !== 1'b0 && cyc < 5000) begin
            @(negedge apb_clk_in);
            cyc++;
        end
        chk($sformatf("%s start seen", tag), uart_txd_out, 0);
    endtask

    // One line segment: level v held for len ticks; 'done' ticks already elapsed
    task automatic seg(input string tag, input logic v, input int len, input int done);
        int t = done;
        int bad = 0;
        int cyc = 0;
        do begin
            if (uart_txd_out !== v || temt_out !== 1'b0) bad++;
            if (bclk_in) t++;
            cyc++;
            @(negedge apb_clk_in);
        end while (t < len && cyc < 1000);
        chk($sformatf("%s bad-cycles", tag), bad, 0);
        chk($sformatf("%s ticks", tag), t, len);
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input int nb, input bit pe,
                         input bit pb, input int stop_t, input bit more, input int done);
        seg($sformatf("%s start", tag), 1'b0, OS, done);
        for (int k = 0; k < nb; k++) seg($sformatf("%s d%0d", tag, k), d[k], OS, 0);
        if (pe) seg($sformatf("%s parity", tag), pb, OS, 0);
        seg($sformatf("%s stop", tag), 1'b1, stop_t, 0);
        if (more) chk($sformatf("%s back-to-back start", tag), uart_txd_out, 0);
        else      chk($sformatf("%s temt after stop", tag), temt_out, 1);
    endtask

    initial begin
        int ov;
        int bad;
        int done;
        int cyc;

        apb_rst_in   = 1'b1;
        thr_wdata_in = '0;
        thr_write_in = 1'b0;
        wls_in       = 2'd3;
        stb_in       = 1'b0;
        pen_in       = 1'b0;
        eps_in       = 1'b0;
        sp_in        = 1'b0;
        bc_in        = 1'b0;
        fifoen_in    = 1'b0;
        txclr_in     = 1'b0;
        afe_in       = 1'b0;
        cts_in       = 1'b0;
        repeat (3) @(negedge apb_clk_in);

        chk("reset txd", uart_txd_out, 1);
        chk("reset thre", thre_out, 1);
        chk("reset temt", temt_out, 1);
        chk("reset level", fifo_level_out, 0);
        chk("reset overflow", overflow_out, 0);
        apb_rst_in = 1'b0;
        repeat (2) @(negedge apb_clk_in);

        // 0xA5, 8N1: 0,1,0,1,0,0,1,0,1,1
        push(8'hA5);
        wait_start("a5");
        frame("a5", 8'hA5, 8, 0, 0, OS, 0, 0);
        chk("a5 thre", thre_out, 1);

        // Break forces the line low from the next cycle
        bc_in = 1'b1;
        @(negedge apb_clk_in);
        chk("break low", uart_txd_out, 0);
        bc_in = 1'b0;
        @(negedge apb_clk_in);
        chk("break released", uart_txd_out, 1);

        // Parity on 0x03 (two ones): even->0, odd->1, stick space->0, stick mark->1
        pen_in = 1'b1; eps_in = 1'b1; sp_in = 1'b0;
        push(8'h03);
        wait_start("par even");
        frame("par even", 8'h03, 8, 1, 0, OS, 0, 0);
        eps_in = 1'b0;
        push(8'h03);
        wait_start("par odd");
        frame("par odd", 8'h03, 8, 1, 1, OS, 0, 0);
        sp_in = 1'b1; eps_in = 1'b1;
        push(8'h03);
        wait_start("par space");
        frame("par space", 8'h03, 8, 1, 0, OS, 0, 0);
        eps_in = 1'b0;
        push(8'h03);
        wait_start("par mark");
        frame("par mark", 8'h03, 8, 1, 1, OS, 0, 0);
        pen_in = 1'b0; sp_in = 1'b0;

        // Extra stop bit: 1.5 bits at 5-bit words, 2 bits otherwise
        wls_in = 2'd0; stb_in = 1'b1;
        push(8'h15);
        wait_start("stb5");
        frame("stb5", 8'h15, 5, 0, 0, OS * 3 / 2, 0, 0);
        wls_in = 2'd3;
        push(8'h5A);
        wait_start("stb8");
        frame("stb8", 8'h5A, 8, 0, 0, 2 * OS, 0, 0);
        stb_in = 1'b0;

        // Non-FIFO mode holds one entry; a second push overflows
        fifoen_in = 1'b0; afe_in = 1'b1; cts_in = 1'b0;
        push(8'h11);
        push(8'h22);
        chk("cap1 overflow pulse", overflow_out, 1);
        chk("cap1 level", fifo_level_out, 1);
        @(negedge apb_clk_in);
        chk("cap1 overflow single", overflow_out, 0);
        txclr_in = 1'b1;
        @(negedge apb_clk_in);
        txclr_in = 1'b0;
        chk("cap1 flush level", fifo_level_out, 0);
        chk("cap1 flush thre", thre_out, 1);
        chk("cap1 flush no overflow", overflow_out, 0);

        // FIFO mode: 17 pushes with CTS held off
        fifoen_in = 1'b1;
        ov = 0;
        for (int i = 0; i < 17; i++) begin
            thr_wdata_in = 8'(i * 29 + 7);
            thr_write_in = 1'b1;
            @(negedge apb_clk_in);
            ov += int'(overflow_out);
        end
        thr_write_in = 1'b0;
        chk("full level", fifo_level_out, 16);
        @(negedge apb_clk_in);
        ov += int'(overflow_out);
        chk("full overflow count", ov, 1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (uart_txd_out !== 1'b1) bad++;
            @(negedge apb_clk_in);
        end
        chk("cts hold line idle", bad, 0);
        chk("cts hold level", fifo_level_out, 16);
        cts_in = 1'b1;
        wait_start("b2b");
        for (int i = 0; i < 16; i++)
            frame($sformatf("b2b%0d", i), 8'(i * 29 + 7), 8, 0, 0, OS, i < 15, 0);
        chk("b2b drained level", fifo_level_out, 0);

        // Flush with a same-cycle push while a character is on the line
        afe_in = 1'b0;
        push(8'h3C);
        push(8'h11);
        wait_start("clr");
        chk("clr level before", fifo_level_out, 1);
        done = 0;
        if (bclk_in) done++;
        thr_wdata_in = 8'h22;
        thr_write_in = 1'b1;
        txclr_in     = 1'b1;
        @(negedge apb_clk_in);
        thr_write_in = 1'b0;
        txclr_in     = 1'b0;
        chk("clr level after", fifo_level_out, 0);
        chk("clr overflow", overflow_out, 0);
        if (bclk_in) done++;
        @(negedge apb_clk_in);
        chk("clr overflow next", overflow_out, 0);
        frame("clr", 8'h3C, 8, 0, 0, OS, 0, done);

        // Reset in the middle of a data bit
        push(8'h00);
        push(8'h00);
        wait_start("rst");
        done = 0;
        cyc = 0;
        while (done < OS + 3 && cyc < 1000) begin
            if (bclk_in) done++;
            cyc++;
            @(negedge apb_clk_in);
        end
        chk("rst mid-data line", uart_txd_out, 0);
        apb_rst_in = 1'b1;
        @(negedge apb_clk_in);
        chk("rst txd", uart_txd_out, 1);
        chk("rst thre", thre_out, 1);
        chk("rst temt", temt_out, 1);
        chk("rst level", fifo_level_out, 0);
        chk("rst overflow", overflow_out, 0);
        apb_rst_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge apb_clk_in);
            if (uart_txd_out !== 1'b1 || temt_out !== 1'b1) bad++;
        end
        chk("post-rst idle", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, maximum character bits; FIFO_DEPTH, default 16, TX FIFO entries (power of 2, >=2); OVERSAMPLE, default 16, bclk ticks per bit (even, >=4).
REQ-002 The block SHALL use one clock, apb_clk_in, with a synchronous, active-high reset, apb_rst_in.
REQ-003 Ports SHALL be, in order:
- apb_clk_in  in  1  clock
- apb_rst_in  in  1  synchronous active-high reset
- bclk_in  in  1  single-cycle tick at OVERSAMPLE x baud
- thr_wdata_in  in  DATA_WIDTH  character to transmit
- thr_write_in  in  1  push strobe
- wls_in  in  2  word length: 0..3 = DATA_WIDTH-3..DATA_WIDTH bits
- stb_in  in  1  extra stop bit
- pen_in  in  1  parity enable
- eps_in  in  1  even parity select
- sp_in  in  1  stick parity
- bc_in  in  1  break control
- fifoen_in  in  1  FIFO enable
- txclr_in  in  1  FIFO flush pulse
- afe_in  in  1  auto flow enable
- cts_in  in  1  clear-to-send, high = clear
- uart_txd_out  out  1  serial line
- thre_out  out  1  FIFO empty
- temt_out  out  1  FIFO empty and shifter idle
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow_out  out  1  one-cycle pulse when a push is dropped

Function
REQ-004 Effective FIFO capacity SHALL be FIFO_DEPTH when fifoen_in=1 and 1 when fifoen_in=0.
REQ-005 A push when occupancy equals capacity SHALL drop the data, leave the FIFO unchanged, and pulse overflow_out in the next cycle.
REQ-006 A simultaneous push and pop SHALL both take effect, leaving occupancy unchanged, including when the FIFO is full.
REQ-007 txclr_in SHALL empty the FIFO in one cycle; it SHALL win over a same-cycle push without pulsing overflow_out, and SHALL NOT abort the character in flight.
REQ-008 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and each bit SHALL last OVERSAMPLE bclk_in ticks.
REQ-009 IDLE SHALL move to START on a bclk_in tick when the FIFO is non-empty and (afe_in=0 or cts_in=1), popping the head into the shift register in that cycle.
REQ-010 START SHALL drive 0 and then go to DATA.
REQ-011 DATA SHALL drive LSB first for the word length selected by wls_in, sampled at the pop, then go to PARITY if pen_in=1, else to STOP.
REQ-012 The parity bit SHALL be: sp=1, eps=1 gives 0; sp=1, eps=0 gives 1; otherwise even (eps=1) or odd (eps=0) over the data bits sent.
REQ-013 STOP SHALL drive 1 for OVERSAMPLE ticks if stb_in=0.
REQ-014 With stb_in=1, STOP SHALL last OVERSAMPLE*3/2 ticks for the minimum word length and 2*OVERSAMPLE ticks otherwise.
REQ-015 STOP SHALL then return to IDLE; back-to-back characters SHALL have no idle bit between them.
REQ-016 CTS deassertion mid-character SHALL take effect only at the next IDLE decision.
REQ-017 uart_txd_out SHALL be registered and change one cycle after the governing bclk_in tick.
REQ-018 bc_in=1 SHALL force uart_txd_out=0 from the next cycle without halting the FSM.
REQ-019 thre_out SHALL equal (occupancy==0), and temt_out SHALL equal thre_out AND state==IDLE.
REQ-020 Configuration changes mid-character SHALL affect only the next character, except bc_in.

Reset
REQ-021 While apb_rst_in=1 at a clock edge, the block SHALL set: state IDLE, FIFO empty, bit and tick counters 0, uart_txd_out=1, thre_out=1, temt_out=1, fifo_level_out=0, overflow_out=0.
REQ-022 Reset mid-character SHALL abort that character immediately, with the line high in the cycle after the reset edge.

Structure
REQ-023 A shared package uart_pkg SHALL hold the FSM state enum, the wls and parity encodings, and the level-width function.
REQ-024 The FIFO SHALL be a sub-module uart_sync_fifo, parameterised by width and depth, with push, pop, clear, full, empty and level.

Verification
REQ-025 The bench SHALL cover:
- Push 0xA5, wls=3, pen=0, stb=0 -> line 0,1,0,1,0,0,1,0,1,1, each 16 ticks; temt_out=1 after the stop bit.
- Push 0x03, wls=3, pen=1, eps=1 -> parity bit 0; with eps=0 -> 1; with sp=1, eps=1 -> 0.
- wls=0, stb=1 -> stop bit lasts 24 ticks; wls=3, stb=1 -> 32 ticks.
- fifoen=1, 17 pushes while afe=1 and cts=0 -> level 16, one overflow pulse, line stays 1; cts=1 -> 16 back-to-back characters.
- Push and txclr_in in the same cycle during transmission -> level 0, current character completes, no overflow pulse.
- Reset asserted in mid-DATA -> line 1 next cycle, all outputs at reset values.
